ro_stress_seq: RTL

Sequencer that sits directly upstream of the ring-oscillator LUT select stage. It drives that stage's Mode and Stress inputs, alternating between stress phases (ring held static at a chosen level) and measure phases (ring free-running). During each measure phase it counts rising edges of the divided ring output over a fixed gate window, giving a per-iteration frequency reading for aging characterisation.

---
 rtl/ro_pkg.sv | 15 +
 rtl/ro_stress_seq_if.sv | 32 +++
 rtl/ro_edge_counter.sv | 45 ++++
 rtl/ro_stress_seq.sv | 125 ++++++++++++
 4 files changed

// File: rtl/ro_pkg.sv
// Shared constants for the ring-oscillator stress sequencer: FSM state codes,
// settle length and LUT-select mode encodings.
package ro_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] MEAS   = 2'd2;
  localparam logic [1:0] STRESS = 2'd3;

  localparam int SETTLE_CYC = 4;

  localparam logic MODE_OSC  = 1'b0;
  localparam logic MODE_HOLD = 1'b1;

endpackage

// File: rtl/ro_stress_seq_if.sv
// Control/status bundle between the stress sequencer and whatever drives it;
// ROIn rides along as the measured ring input.
interface ro_stress_seq_if #(
  parameter int STRESS_W = 24,
  parameter int GATE_W   = 16,
  parameter int CNT_W    = 20
);
  logic                Start;
  logic                Abort;
  logic                StressLevel;
  logic [STRESS_W-1:0] StressCycles;
  logic [GATE_W-1:0]   GateCycles;
  logic [7:0]          Repeat;
  logic                ROIn;
  logic                Mode;
  logic                Stress;
  logic                Busy;
  logic [CNT_W-1:0]    Count;
  logic                CountValid;
  logic                Overflow;
  logic                Done;

  modport master (
    output Start, Abort, StressLevel, StressCycles, GateCycles, Repeat, ROIn,
    input  Mode, Stress, Busy, Count, CountValid, Overflow, Done
  );

  modport slave (
    input  Start, Abort, StressLevel, StressCycles, GateCycles, Repeat, ROIn,
    output Mode, Stress, Busy, Count, CountValid, Overflow, Done
  );
endinterface

// File: rtl/ro_edge_counter.sv
// Synchronises the divided ring output, detects rising edges and counts them
// while enabled; count saturates at all-ones and ovf stays set until clr.
module ro_edge_counter #(
  parameter int CNT_W = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] NEAR_SAT = ~CNT_W'(1);

  logic sync1, sync2, sync3;
  logic rise;

  assign rise = sync2 & ~sync3;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (en && rise && !(&cnt)) begin
      cnt <= cnt + CNT_W'(1);
      // Flag on the increment that lands on all-ones, not on a later edge.
      if (cnt == NEAR_SAT) ovf <= 1'b1;
    end
  end

endmodule

// File: rtl/ro_stress_seq.sv
// Alternates static stress phases with gated ring-frequency measurements;
// one baseline measurement plus Repeat stress+measure iterations per Start.
module ro_stress_seq
  import ro_pkg::*;
#(
  parameter int STRESS_W = 24,
  parameter int GATE_W   = 16,
  parameter int CNT_W    = 20
) (
  input logic            CLK,
  input logic            RST,
  ro_stress_seq_if.slave bus
);

  localparam int PW = (STRESS_W > GATE_W) ? STRESS_W : GATE_W;

  logic [1:0]          state;
  logic [PW-1:0]       pcnt;
  logic                pdone;
  logic [7:0]          iter;
  logic [7:0]          rep_q;
  logic [STRESS_W-1:0] slen_q;
  logic [GATE_W-1:0]   glen_q;
  logic                lvl_q;
  logic                cv_q;
  logic                done_q;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    count_q;
  logic                ovf;
  logic                clr;
  logic                en;

  assign pdone = (pcnt == '0);
  // An abort on the last settle cycle must leave the previous result intact.
  assign clr   = (state == SETTLE) && pdone && !bus.Abort;
  assign en    = (state == MEAS);

  ro_edge_counter #(.CNT_W(CNT_W)) u_edge_counter (
    .clk (CLK),
    .rst (RST),
    .din (bus.ROIn),
    .clr (clr),
    .en  (en),
    .cnt (cnt),
    .ovf (ovf)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      pcnt    <= '0;
      iter    <= '0;
      rep_q   <= '0;
      slen_q  <= '0;
      glen_q  <= '0;
      lvl_q   <= 1'b0;
      cv_q    <= 1'b0;
      done_q  <= 1'b0;
      count_q <= '0;
    end else begin
      cv_q   <= 1'b0;
      done_q <= 1'b0;
      if (cv_q) count_q <= cnt;
      if (bus.Abort) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (bus.Start) begin
              state  <= SETTLE;
              pcnt   <= PW'(SETTLE_CYC - 1);
              iter   <= '0;
              rep_q  <= bus.Repeat;
              lvl_q  <= bus.StressLevel;
              slen_q <= (bus.StressCycles == '0) ? STRESS_W'(1) : bus.StressCycles;
              glen_q <= (bus.GateCycles == '0) ? GATE_W'(1) : bus.GateCycles;
            end
          end
          SETTLE: begin
            if (pdone) begin
              state <= MEAS;
              pcnt  <= PW'(glen_q) - PW'(1);
            end else begin
              pcnt <= pcnt - PW'(1);
            end
          end
          MEAS: begin
            if (pdone) begin
              cv_q <= 1'b1;
              if (iter < rep_q) begin
                state <= STRESS;
                pcnt  <= PW'(slen_q) - PW'(1);
              end else begin
                state  <= IDLE;
                done_q <= 1'b1;
              end
            end else begin
              pcnt <= pcnt - PW'(1);
            end
          end
          STRESS: begin
            if (pdone) begin
              state <= SETTLE;
              pcnt  <= PW'(SETTLE_CYC - 1);
              iter  <= iter + 8'd1;
            end else begin
              pcnt <= pcnt - PW'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Counter is frozen in the result cycle, so it can be shown before it is captured.
  assign bus.Count      = cv_q ? cnt : count_q;
  assign bus.CountValid = cv_q;
  assign bus.Overflow   = ovf;
  assign bus.Done       = done_q;
  assign bus.Busy       = (state != IDLE);
  assign bus.Mode       = (state == SETTLE || state == MEAS) ? MODE_OSC : MODE_HOLD;
  assign bus.Stress     = (state == STRESS) & lvl_q;

endmodule
